// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: window base, word offsets of the
// register map, and the active-low 7-segment glyphs.
package mmio_pkg;

    localparam logic [19:0] IO_BASE_DEFAULT = 20'hFFFFF;

    // Word indices, i.e. addr[11:2] of each register
    localparam logic [9:0] OFF_DIGITS = 10'h000;  // 0x000
    localparam logic [9:0] OFF_LED    = 10'h018;  // 0x060
    localparam logic [9:0] OFF_SW     = 10'h01C;  // 0x070
    localparam logic [9:0] OFF_BTN    = 10'h01E;  // 0x078

    // Active-low glyphs, bit 0 = a ... bit 6 = g, bit 7 = dp (always off)
    localparam logic [15:0][7:0] SEG_PATTERNS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0] SEG_AN_RESET = 8'hFE;
    localparam logic [7:0] SEG_CA_RESET = 8'hC0;

endpackage

// File: rtl/mmio_responder_seg_decoder.sv
// Hex nibble to active-low 7-segment pattern, purely combinational.
module seg_decoder
    import mmio_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    assign pattern = SEG_PATTERNS[nibble];

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped peripheral block in the 0xFFFFF000 window: digit/LED registers,
// switch/button synchronisers and the multiplexed 8-digit 7-segment scanner.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int          SCAN_DIV = 50000,
    parameter logic [19:0] IO_BASE  = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        io_sel,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_ca
);

    localparam int               CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [9:0]       word;
    logic             wr_digits;
    logic             wr_led;
    logic [31:0]      digits;
    logic [23:0]      sw_meta;
    logic [23:0]      sw_sync;
    logic [4:0]       btn_meta;
    logic [4:0]       btn_sync;
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       idx;
    logic             scan_wrap;
    logic [7:0]       digit_pattern;
    logic             unused_addr_bits;

    assign io_sel           = (mem_addr[31:12] == IO_BASE);
    assign word             = mem_addr[11:2];
    assign unused_addr_bits = ^mem_addr[1:0];

    assign wr_digits = mem_we && io_sel && (word == OFF_DIGITS);
    assign wr_led    = mem_we && io_sel && (word == OFF_LED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= '0;
            led    <= '0;
        end else begin
            if (wr_digits) digits <= mem_write_data;
            if (wr_led)    led    <= mem_write_data[23:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    // Register state before the edge, so a same-cycle write reads old data
    always_comb begin
        mem_read_data = 32'h0;
        if (io_sel) begin
            case (word)
                OFF_DIGITS: mem_read_data = digits;
                OFF_LED:    mem_read_data = {8'h0, led};
                OFF_SW:     mem_read_data = {8'h0, sw_sync};
                OFF_BTN:    mem_read_data = {27'h0, btn_sync};
                default:    mem_read_data = 32'h0;
            endcase
        end
    end

    assign scan_wrap = (scan_cnt == CNT_LAST);

    seg_decoder u_seg_decoder (
        .nibble  (digits[{idx, 2'b00} +: 4]),
        .pattern (digit_pattern)
    );

    // Outputs are registered from the current idx/digits, hence one clock behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg_an   <= SEG_AN_RESET;
            seg_ca   <= SEG_CA_RESET;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            seg_an <= ~(8'b1 << idx);
            seg_ca <= digit_pattern;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with a short scan period.
module tb_mmio_responder;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        io_sel;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_ca;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [7:0] EXP_AN [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    localparam logic [7:0] EXP_CA [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    mmio_responder #(.SCAN_DIV(SCAN_DIV), .IO_BASE(20'hFFFFF)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .io_sel         (io_sel),
        .sw             (sw),
        .btn            (btn),
        .led            (led),
        .seg_an         (seg_an),
        .seg_ca         (seg_ca)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst            = 1'b1;
        mem_we         = 1'b0;
        mem_addr       = 32'hFFFFF000;
        mem_write_data = 32'h0;
        sw             = '0;
        btn            = '0;
        tick();
        tick();
        check("reset_led", 32'(led), 32'h0);
        check("reset_an", 32'(seg_an), 32'hFE);
        check("reset_ca", 32'(seg_ca), 32'hC0);

        // Release; edges counted from 1 after this point
        rst = 1'b0;
        #1;
        check("digits_read_0", mem_read_data, 32'h0);
        check("io_sel_base", 32'(io_sel), 32'h1);
        for (int n = 1; n <= 4; n++) tick();
        check("an_after_4", 32'(seg_an), 32'hFE);
        tick();
        check("an_after_5", 32'(seg_an), 32'hFD);

        // LED write with same-cycle read of the old value
        mem_addr       = 32'hFFFFF060;
        mem_write_data = 32'h00ABCDEF;
        mem_we         = 1'b1;
        #1;
        check("led_same_cycle", mem_read_data, 32'h0);
        tick();
        mem_we = 1'b0;
        #1;
        check("led_out", 32'(led), 32'h00ABCDEF);
        check("led_readback", mem_read_data, 32'h00ABCDEF);

        // Synchronisers: two edges of latency
        mem_addr = 32'hFFFFF070;
        sw       = 24'h123456;
        btn      = 5'b10101;
        #1;
        check("sw_before_edge", mem_read_data, 32'h0);
        tick();
        check("sw_after_1", mem_read_data, 32'h0);
        tick();
        check("sw_after_2", mem_read_data, 32'h00123456);
        mem_addr = 32'hFFFFF078;
        #1;
        check("btn_read", mem_read_data, 32'h00000015);

        // Ignored writes: read-only, unmapped, outside window
        mem_addr       = 32'hFFFFF070;
        mem_write_data = 32'hFFFFFFFF;
        mem_we         = 1'b1;
        #1;
        check("io_sel_sw", 32'(io_sel), 32'h1);
        tick();
        mem_we = 1'b0;
        #1;
        check("sw_not_written", mem_read_data, 32'h00123456);

        mem_addr       = 32'hFFFFF100;
        mem_write_data = 32'h11111111;
        mem_we         = 1'b1;
        #1;
        check("io_sel_unmapped", 32'(io_sel), 32'h1);
        check("unmapped_read", mem_read_data, 32'h0);
        tick();
        mem_we = 1'b0;
        #1;
        check("unmapped_read_after", mem_read_data, 32'h0);

        mem_addr       = 32'h00001060;
        mem_write_data = 32'h22222222;
        mem_we         = 1'b1;
        #1;
        check("io_sel_outside", 32'(io_sel), 32'h0);
        check("outside_read", mem_read_data, 32'h0);
        tick();
        mem_we = 1'b0;
        check("led_unchanged", 32'(led), 32'h00ABCDEF);
        mem_addr = 32'hFFFFF000;
        #1;
        check("digits_unchanged", mem_read_data, 32'h0);

        // Full scan walk from a fresh reset, DIGITS written on edge 1
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        mem_addr       = 32'hFFFFF000;
        mem_write_data = 32'h76543210;
        mem_we         = 1'b1;
        tick();
        mem_we = 1'b0;
        #1;
        check("digits_readback", mem_read_data, 32'h76543210);
        tick();
        tick();
        tick();
        for (int k = 0; k <= 8; k++) begin
            check($sformatf("walk_an_%0d", k), 32'(seg_an), 32'(EXP_AN[k % 8]));
            check($sformatf("walk_ca_%0d", k), 32'(seg_ca), 32'(EXP_CA[k % 8]));
            if (k < 8) for (int j = 0; j < 4; j++) tick();
        end

        // Asynchronous reset mid-dwell at idx 5
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        mem_addr       = 32'hFFFFF060;
        mem_write_data = 32'h00FFFFFF;
        mem_we         = 1'b1;
        tick();
        mem_we = 1'b0;
        for (int n = 2; n <= 21; n++) tick();
        check("pre_rst_an", 32'(seg_an), 32'hDF);
        check("pre_rst_led", 32'(led), 32'h00FFFFFF);
        rst = 1'b1;
        #1;
        check("async_led", 32'(led), 32'h0);
        check("async_an", 32'(seg_an), 32'hFE);
        check("async_ca", 32'(seg_ca), 32'hC0);
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) tick();
        check("post_rst_an_4", 32'(seg_an), 32'hFE);
        tick();
        check("post_rst_an_5", 32'(seg_an), 32'hFD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
